// File: rtl/bcd_scan_disp.sv
// Two-digit multiplexed 7-segment driver for the x5 BCD converter's tens/units pair.
// Optional leading-zero blanking of the tens digit: define BCD_SCAN_DISP_LZB_EN.
module bcd_scan_disp #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic [3:0] u,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dig_err
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [3:0]    d_r;
  logic [3:0]    u_r;
  logic [CW-1:0] cnt;
  logic          sel;
  logic [3:0]    shown;
  logic          blank;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Digit currently being scanned out, and whether it is a suppressed leading zero.
  always_comb begin
    shown = sel ? d_r : u_r;
`ifdef BCD_SCAN_DISP_LZB_EN
    blank = sel && (d_r == 4'd0);
`else
    blank = 1'b0;
`endif
  end

  // Outputs are computed from the pre-edge latch/select state, so they lag those by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r     <= 4'd0;
      u_r     <= 4'd0;
      cnt     <= '0;
      sel     <= 1'b0;
      seg     <= 7'h00;
      an      <= 2'b00;
      dig_err <= 1'b0;
    end else begin
      if (ld) begin
        d_r <= d;
        u_r <= u;
      end
      if (cnt == LAST) begin
        cnt <= '0;
        sel <= ~sel;
      end else begin
        cnt <= cnt + CW'(1);
      end
      an      <= sel ? 2'b10 : 2'b01;
      seg     <= blank ? 7'h00 : dec(shown);
      dig_err <= (d_r > 4'd9) | (u_r > 4'd9);
    end
  end

endmodule

// File: tb/tb_bcd_scan_disp.sv
// Self-checking bench for bcd_scan_disp: directed scenarios plus random traffic against a scan-position model.
module tb_bcd_scan_disp;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld  = 1'b0;
  logic [3:0] d   = 4'd0;
  logic [3:0] u   = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dig_err;

  int passed = 0;
  int total  = 0;

  // Reference state: digits as latched, and non-reset edges since the last reset.
  int m_d = 0;
  int m_u = 0;
  int steps = 0;

  logic [6:0] seg_tab [16];

  bcd_scan_disp #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .ld(ld), .d(d), .u(u),
    .seg(seg), .an(an), .dig_err(dig_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // One clock edge with the given inputs; outputs are compared with the model, then the model advances.
  task automatic step(input logic r, input logic l, input logic [3:0] dv, input logic [3:0] uv);
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_err;
    int         tens_slot;
    rst = r; ld = l; d = dv; u = uv;
    @(posedge clk);
    if (r) begin
      e_seg = 7'h00; e_an = 2'b00; e_err = 1'b0;
    end else begin
      tens_slot = (steps / DIV) % 2;
      e_an  = tens_slot ? 2'b10 : 2'b01;
      e_seg = tens_slot ? seg_tab[m_d] : seg_tab[m_u];
`ifdef BCD_SCAN_DISP_LZB_EN
      if (tens_slot && m_d == 0) e_seg = 7'h00;
`endif
      e_err = (m_d > 9) || (m_u > 9);
    end
    #1;
    check("seg", seg, e_seg);
    check("an", {5'd0, an}, {5'd0, e_an});
    check("dig_err", {6'd0, dig_err}, {6'd0, e_err});
    if (r) begin
      steps = 0; m_d = 0; m_u = 0;
    end else begin
      steps++;
      if (l) begin m_d = int'(dv); m_u = int'(uv); end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd9, 4'd9);
    idle(3);

    // 25, held over two scans
    step(1'b0, 1'b1, 4'd2, 4'd5);
    idle(2 * 2 * DIV);

    // 45, one load pulse then three scans
    step(1'b0, 1'b1, 4'd4, 4'd5);
    idle(3 * 2 * DIV);

    // invalid tens digit, then a valid pair clears the flag
    step(1'b0, 1'b1, 4'hA, 4'd3);
    idle(2 * DIV + 1);
    step(1'b0, 1'b1, 4'd1, 4'd0);
    idle(2 * DIV);

    // reset while the tens digit is displayed
    for (int i = 0; i < 2 * DIV && ((steps / DIV) % 2) == 0; i++) idle(1);
    idle(1);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    idle(2 * DIV + 1);

    // load on the very edge that toggles select
    for (int i = 0; i < DIV && (steps % DIV) != DIV - 1; i++) idle(1);
    step(1'b0, 1'b1, 4'd7, 4'd8);
    idle(2 * DIV + 1);

    // tens digit of zero
    step(1'b0, 1'b1, 4'd0, 4'd5);
    idle(2 * DIV + 1);

    // random traffic including mid-slot loads, held loads and occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
